// File: rtl/mips_bus_arbiter_pkg.sv
// Shared CPU-wide codes: common data width plus the bus arbiter's state and requester encodings.
package codes;

   typedef logic [31:0] size_t;

   typedef enum logic [1:0] {IDLE, BUS, RESP} arb_state_t;

   typedef enum logic {REQ_FETCH, REQ_DATA} requester_t;

   localparam logic [3:0] BYTEEN_WORD = 4'b1111;

endpackage

// File: rtl/mips_bus_arbiter_if.sv
// Avalon memory-mapped master bus between the CPU arbiter and the top-level pins.
interface mips_bus_arbiter_if;
   import codes::*;

   size_t      address;
   logic       read;
   logic       write;
   size_t      writedata;
   logic [3:0] byteenable;
   size_t      readdata;
   logic       waitrequest;

   modport master (
      output address, read, write, writedata, byteenable,
      input  readdata, waitrequest
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output readdata, waitrequest
   );

endinterface

// File: rtl/mips_bus_arbiter.sv
// Serialises instruction-fetch and load/store requests onto one Avalon master port,
// alternating grants under contention and returning read data to the owner.
module mips_bus_arbiter
   import codes::*;
#(
   parameter int WAIT_CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  fetch_valid,
   input  size_t                 fetch_addr,
   output logic                  fetch_ready,
   output logic                  fetch_resp_valid,
   output size_t                 fetch_rdata,

   input  logic                  data_valid,
   input  logic                  data_write,
   input  size_t                 data_addr,
   input  size_t                 data_wdata,
   input  logic [3:0]            data_byteen,
   output logic                  data_ready,
   output logic                  data_resp_valid,
   output size_t                 data_rdata,

   mips_bus_arbiter_if.master    bus,

   output logic                  busy,
   output logic [WAIT_CNT_W-1:0] stall_cycles
);

   arb_state_t state;
   requester_t last_grant;
   logic       grant_fetch;
   logic       grant_data;

   // Fetch wins unless data is also asking and fetch was served last.
   always_comb begin
      grant_fetch = fetch_valid && (!data_valid || last_grant == REQ_DATA);
      grant_data  = data_valid && !grant_fetch;
   end

   assign fetch_ready      = (state == IDLE) && grant_fetch;
   assign data_ready       = (state == IDLE) && grant_data;
   assign fetch_resp_valid = (state == RESP) && (last_grant == REQ_FETCH);
   assign data_resp_valid  = (state == RESP) && (last_grant == REQ_DATA);
   assign busy             = (state != IDLE);

   // NOTE: every register here is sequential state, so it is written with <= only;
   // a blocking write would let later statements in this block see the new value.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         last_grant     <= REQ_DATA;
         bus.address    <= '0;
         bus.read       <= 1'b0;
         bus.write      <= 1'b0;
         bus.writedata  <= '0;
         bus.byteenable <= '0;
         fetch_rdata    <= '0;
         data_rdata     <= '0;
         stall_cycles   <= '0;
      end else begin
         if ((bus.read || bus.write) && bus.waitrequest && (stall_cycles != '1))
            stall_cycles <= stall_cycles + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};

         case (state)
            IDLE: begin
               if (grant_fetch) begin
                  bus.address    <= fetch_addr;
                  bus.read       <= 1'b1;
                  bus.write      <= 1'b0;
                  bus.byteenable <= BYTEEN_WORD;
                  last_grant     <= REQ_FETCH;
                  state          <= BUS;
               end else if (grant_data) begin
                  bus.address    <= data_addr;
                  bus.read       <= ~data_write;
                  bus.write      <= data_write;
                  bus.writedata  <= data_wdata;
                  bus.byteenable <= data_byteen;
                  last_grant     <= REQ_DATA;
                  state          <= BUS;
               end
            end

            BUS: begin
               // Avalon reads are combinational: readdata is valid when waitrequest drops.
               if (!bus.waitrequest) begin
                  if (bus.read) begin
                     if (last_grant == REQ_FETCH) fetch_rdata <= bus.readdata;
                     else                         data_rdata  <= bus.readdata;
                  end
                  bus.read  <= 1'b0;
                  bus.write <= 1'b0;
                  state     <= RESP;
               end
            end

            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Shares the single Avalon memory-mapped master port of the bus CPU between two requesters: the instruction-fetch path (read-only) and the load/store data path (read/write). It serialises their transactions, holds each Avalon request stable across `waitrequest`, and returns read data to the owning requester. It alternates grants fairly under contention. It sits between the CPU datapath/control and the top-level `address/read/write/writedata/byteenable/readdata/waitrequest` pins.

## Interface
- `WAIT_CNT_W`, 16: width of the saturating stall-cycle counter.

- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `fetch_valid` in 1: fetch read request; held until `fetch_ready`.
- `fetch_addr` in 32: fetch byte address; must be stable while `fetch_valid`.
- `fetch_ready` out 1: the request is accepted this cycle.
- `fetch_resp_valid` out 1: one-cycle pulse carrying `fetch_rdata`.
- `fetch_rdata` out 32: raw bus `readdata`, with no endian swap.
- `data_valid`, `data_write` in 1 each: data request and direction (1 = write).
- `data_addr` in 32: data byte address.
- `data_wdata` in 32: write data for a data write.
- `data_byteen` in 4: byte enables for a data access.
- `data_ready` out 1: the data request is accepted this cycle.
- `data_resp_valid` out 1: one-cycle completion pulse, for reads and writes.
- `data_rdata` out 32: raw bus `readdata`.
- `address` out 32, `read` out 1, `write` out 1, `writedata` out 32, `byteenable` out 4: Avalon master outputs.
- `waitrequest` in 1, `readdata` in 32: Avalon slave responses.
- `busy` out 1: high when the state is not IDLE.
- `stall_cycles` out WAIT_CNT_W: saturating count of cycles with `(read|write) && waitrequest`.

## Operation
- States: IDLE, BUS, RESP, using `arb_state_t`.
- **IDLE**
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the one not in `last_grant`.
  - The granted `*_ready` is asserted combinationally this cycle. The request is latched into the output registers, `last_grant` is set to the granted port, and the state moves to BUS.
  - If neither is valid, stay in IDLE.
- **Request latching**
  - A fetch drives `read`=1, `write`=0 and `byteenable`=4'b1111.
  - A data request drives `read`=~`data_write`, `write`=`data_write`, `writedata`=`data_wdata` and `byteenable`=`data_byteen`.
- **BUS**
  - `read` or `write` is asserted from the registers; all Avalon outputs are held constant.
  - When `waitrequest`=0, capture `readdata` into the granted port's rdata register, deassert `read`/`write`, and move to RESP.
  - When `waitrequest`=1, stay in BUS.
- **RESP**: the granted `*_resp_valid` is high for exactly one cycle, then the state returns to IDLE.
- **Ready rules**
  - `*_ready` is never asserted outside IDLE.
  - At most one `*_ready` is high in any cycle.
- **Reads are combinational**: read data is valid in the same cycle that `waitrequest` is low. There is no readdatavalid signal.
- **Data writes** also produce `data_resp_valid`; `data_rdata` is don't-care and holds its previous value.
- **Stall counter**: `stall_cycles` increments when `(read|write) && waitrequest`. It saturates at all-ones and clears only on reset.
- **Reset values**
  - State IDLE, `last_grant`=DATA, so the first contended cycle grants FETCH.
  - `address`=0, `writedata`=0, `byteenable`=0, `read`=0, `write`=0.
  - All `*_ready` and `*_resp_valid` = 0, both rdata registers = 0, `stall_cycles`=0, `busy`=0.
- **Reset mid-transaction**: the next edge returns to IDLE with `read`/`write`=0. The pending response is dropped and no `resp_valid` pulse is produced.

## Timing
- Accept in cycle N (IDLE, `ready`=1).
- Bus request is visible from cycle N+1.
- If `waitrequest`=0 in N+1, `resp_valid` is high in N+2 and the next accept is possible in N+3.
- Each waitrequest-high cycle adds exactly one cycle of latency.
- Minimum spacing is 3 cycles per transaction.
- A requester deasserting `valid` before `ready` is legal; nothing is issued.
- A new request presented in RESP is not accepted until the following IDLE cycle.

## Structure
- Add to the shared `codes` package:
  - `arb_state_t` enum {IDLE, BUS, RESP};
  - `requester_t` enum {REQ_FETCH, REQ_DATA};
  - the constant `BYTEEN_WORD` = 4'b1111.
- Use `size_t` for all 32-bit address and data signals.
- No sub-module; the block is a single FSM with registered outputs.

## Test plan
- **Single fetch, no wait**: `fetch_valid` with addr 0xBFC00000, `waitrequest`=0, `readdata`=0x3C021234 -> `fetch_ready` at N, `read`=1 and `address`=0xBFC00000 at N+1, `fetch_resp_valid`=1 with `fetch_rdata`=0x3C021234 at N+2.
- **Data write with 3 wait cycles**: addr 0x1000, wdata 0xDEADBEEF, byteen 4'b0011 -> `write`/`address`/`writedata`/`byteenable` stable for 4 cycles, `data_resp_valid` one cycle later, `stall_cycles`=3.
- **Contention**: both valid continuously after reset -> grants in order FETCH, DATA, FETCH, DATA; never both `ready` in the same cycle.
- **Reset in BUS** with `waitrequest`=1 -> next cycle `read`=0, `busy`=0, no `resp_valid`; the following request works normally.
- **Stall counter saturation** with WAIT_CNT_W=4 and 20 stall cycles -> `stall_cycles`=15.
- **Request withdrawn while BUS busy** (data `valid` 1 cycle during a fetch) -> no data transaction issued and `data_ready` never asserted.
